byte_serial_adder_ctrl: RTL and testbench
=========================================

BYTE_SERIAL_ADDER_CTRL -- requirements
Module: byte_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the operand width in bytes (W = 8*NBYTES); legal range 2..16.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: operand set presented.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have ports in_a and in_b, input, W each: the two operands.
REQ-007 SHALL have port in_cin, input, 1: initial carry-in.
REQ-008 SHALL have ports rca_a and rca_b, output, 8 each: the byte operands driven to the external 8-bit ripple-carry adder.
REQ-009 SHALL have port rca_cin, output, 1: the carry driven to the adder.
REQ-010 SHALL have ports rca_sum, input, 8, and rca_cout, input, 1: the combinational result returned by the adder in the same cycle.
REQ-011 SHALL have port out_valid, output, 1: a result is held.
REQ-012 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-013 SHALL have port out_sum, output, W: the full-width sum.
REQ-014 SHALL have ports out_cout, out_ovf and out_zero, output, 1 each: carry-out, signed overflow and zero-result flags.

Function
REQ-015 SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-016 SHALL assert in_ready only in IDLE, with no combinational path from out_ready.
REQ-017 SHALL, in IDLE when in_valid and in_ready are both high, register in_a, in_b and in_cin, clear the byte index to 0 and enter ADD.
REQ-018 SHALL, in ADD, drive rca_a with byte idx of the registered A, rca_b with byte idx of the registered B, and rca_cin with the registered cin when idx is 0 or with the carry register otherwise.
REQ-019 SHALL, on each ADD cycle, write rca_sum into out_sum byte idx, load rca_cout into the carry register and increment idx.
REQ-020 SHALL, on the ADD cycle where idx equals NBYTES-1, enter DONE, set out_cout to rca_cout and set out_ovf to (A[W-1] == B'[W-1]) and (rca_sum[7] != A[W-1]), where B' is the operand actually presented to the adder.
REQ-021 SHALL set out_zero to 1 in DONE exactly when out_sum is zero.
REQ-022 SHALL take exactly NBYTES+1 cycles from accept to out_valid: accept at edge T, ADD during T+1..T+NBYTES, out_valid high after edge T+NBYTES.
REQ-023 SHALL hold out_valid, out_sum and all flags stable in DONE until out_valid and out_ready are both high, then return to IDLE.
REQ-024 SHALL not accept a new operand set in the same cycle as the output handshake; the earliest new accept is the following cycle.
REQ-025 SHALL drive rca_a, rca_b and rca_cin to 0 outside ADD.
REQ-026 SHALL ignore in_valid in ADD and DONE, and ignore out_ready in IDLE and ADD.

Reset
REQ-027 SHALL, while reset is high, immediately force state IDLE, idx 0, carry register 0, out_sum 0, out_cout/out_ovf/out_zero 0, out_valid 0 and in_ready 1.
REQ-028 SHALL, on reset asserted mid-ADD or in DONE, discard the operation, with no out_valid pulse produced for it.

Configuration
REQ-029 SHALL, with macro BSA_SUBTRACT_EN defined, add input port op_sub (1 bit) captured at accept; when op_sub is 1, B' is the bitwise inverse of B and the initial carry is 1 regardless of in_cin, computing A-B.
REQ-030 SHALL, with BSA_SUBTRACT_EN undefined, have no op_sub port and always use B' = B and the initial carry equal to in_cin.

Verification (NBYTES=4)
REQ-031 SHALL pass this bench: A=0xFFFFFFFF, B=0x00000001, cin=0 -> out_sum=0x00000000, cout=1, ovf=0, zero=1, out_valid 5 cycles after accept.
REQ-032 SHALL pass this bench: A=0x7FFFFFFF, B=0x00000001, cin=0 -> out_sum=0x80000000, cout=0, ovf=1, zero=0; rca_cin observed as 0,1,1,1 over the ADD cycles.
REQ-033 SHALL pass this bench: A=0x12345678, B=0x11111111, cin=1, out_ready held 0 for 10 cycles -> out_sum=0x2345678A held stable with in_ready=0 throughout, then IDLE one cycle after out_ready=1.
REQ-034 SHALL pass this bench: reset pulsed during the 2nd ADD cycle -> no out_valid; all outputs 0 and in_ready 1 while reset is high; the next operation completes correctly.
REQ-035 SHALL pass this bench, with BSA_SUBTRACT_EN defined: A=5, B=7, op_sub=1 -> out_sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-036 SHALL pass this bench: back-to-back transactions with out_ready tied to 1 -> accepts spaced exactly NBYTES+2 cycles apart.

Source files
------------

// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial W-bit adder controller driving an external 8-bit ripple-carry adder.
// Define BSA_SUBTRACT_EN to add the op_sub input for A-B.
module byte_serial_adder_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
`ifdef BSA_SUBTRACT_EN
  input  logic                  op_sub,
`endif
  output logic [7:0]            rca_a,
  output logic [7:0]            rca_b,
  output logic                  rca_cin,
  input  logic [7:0]            rca_sum,
  input  logic                  rca_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  out_zero
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  b_sel;
  logic          c_sel;
  logic          last;

  // b_q holds the operand as seen by the adder (inverted for subtract)
  always_comb begin
    b_sel = in_b;
    c_sel = in_cin;
`ifdef BSA_SUBTRACT_EN
    if (op_sub) begin
      b_sel = ~in_b;
      c_sel = 1'b1;
    end
`endif
  end

  assign last = (idx_q == IW'(NBYTES - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    rca_a   = 8'h00;
    rca_b   = 8'h00;
    rca_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = b_sel;
          cin_d   = c_sel;
          idx_d   = '0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        rca_a   = a_q[{idx_q, 3'b000} +: 8];
        rca_b   = b_q[{idx_q, 3'b000} +: 8];
        rca_cin = (idx_q == '0) ? cin_q : carry_q;
        sum_d[{idx_q, 3'b000} +: 8] = rca_sum;
        carry_d = rca_cout;
        idx_d   = idx_q + IW'(1);
        if (last) begin
          idx_d   = '0;
          cout_d  = rca_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                    (rca_sum[7] != a_q[W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = (state_q == DONE) && (sum_q == '0);

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Scoreboard bench for byte_serial_adder_ctrl (NBYTES=4) with a behavioural RCA.
// Build with BSA_SUBTRACT_EN to also cover the subtract path.
module tb_byte_serial_adder_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef BSA_SUBTRACT_EN
  logic         op_sub;
`endif
  logic [7:0]   rca_a;
  logic [7:0]   rca_b;
  logic         rca_cin;
  logic [7:0]   rca_sum;
  logic         rca_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign {rca_cout, rca_sum} =
    {1'b0, rca_a} + {1'b0, rca_b} + 9'(rca_cin);

  byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
`ifdef BSA_SUBTRACT_EN
    .op_sub(op_sub),
`endif
    .rca_a(rca_a),
    .rca_b(rca_b),
    .rca_cin(rca_cin),
    .rca_sum(rca_sum),
    .rca_cout(rca_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout),
    .out_ovf(out_ovf),
    .out_zero(out_zero)
  );

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic cin);
    exp_t       e;
    logic [W:0] r;
    r      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    e.zero = (r[W-1:0] == '0);
    return e;
  endfunction

  task automatic accept_op(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic cin,
                           input bit push,
                           input exp_t e);
    bit ok = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_hs in_ready/out_valid=%b required 10",
               {in_ready, out_valid});
    end
    checks++;
    if ({out_sum, out_cout, out_ovf, out_zero} !== '0) begin
      failures++;
      $display("FAIL reset_out sum=%h c=%b o=%b z=%b required zeros",
               out_sum, out_cout, out_ovf, out_zero);
    end
    checks++;
    if ({rca_a, rca_b, rca_cin} !== 17'h0) begin
      failures++;
      $display("FAIL reset_rca a=%h b=%h c=%b required 0",
               rca_a, rca_b, rca_cin);
    end
    reset = 1'b0;
  endtask

  task automatic test_carry_wrap;
    exp_t e, got;
    int   lat = -1;
    e = '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
    accept_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, e);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    checks++;
    if (lat != NB + 1) begin
      failures++;
      $display("FAIL wrap_latency got=%0d required %0d", lat, NB + 1);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL wrap_sb_empty got=0 required 1");
    end else begin
      e   = sb.pop_front();
      got = {out_sum, out_cout, out_ovf, out_zero};
      if (got !== e) begin
        failures++;
        $display("FAIL wrap_result got=%h/%b%b%b required %h/%b%b%b",
                 got.sum, got.cout, got.ovf, got.zero,
                 e.sum, e.cout, e.ovf, e.zero);
      end
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL wrap_release got=%b required 10",
               {in_ready, out_valid});
    end
  endtask

  task automatic test_ovf;
    exp_t        e, got;
    logic [NB-1:0] cins;
    logic        early = 1'b0;
    logic [15:0] byte0 = 16'h0;
    e = '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
    accept_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, e);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      cins[k] = rca_cin;
      if (k == 0) byte0 = {rca_a, rca_b};
      if (out_valid) early = 1'b1;
    end
    checks++;
    if (cins !== 4'b1110) begin
      failures++;
      $display("FAIL ovf_rca_cin got=%b required 1110 (msb=last)", cins);
    end
    checks++;
    if (byte0 !== 16'hFF01) begin
      failures++;
      $display("FAIL ovf_byte0 got=%h required ff01", byte0);
    end
    @(negedge clk);
    checks++;
    if (early || !out_valid) begin
      failures++;
      $display("FAIL ovf_valid_timing early=%b valid=%b required 0/1",
               early, out_valid);
    end
    checks++;
    e   = sb.pop_front();
    got = {out_sum, out_cout, out_ovf, out_zero};
    if (got !== e) begin
      failures++;
      $display("FAIL ovf_result got=%h/%b%b%b required %h/%b%b%b",
               got.sum, got.cout, got.ovf, got.zero,
               e.sum, e.cout, e.ovf, e.zero);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_hold;
    exp_t e, got;
    bit   ok = 0;
    e = '{sum: 32'h2345_678A, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    accept_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1, e);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_timeout out_valid=%b required 1", out_valid);
    end
    checks++;
    e   = sb.pop_front();
    got = {out_sum, out_cout, out_ovf, out_zero};
    if (got !== e) begin
      failures++;
      $display("FAIL hold_result got=%h/%b%b%b required %h/%b%b%b",
               got.sum, got.cout, got.ovf, got.zero,
               e.sum, e.cout, e.ovf, e.zero);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got = {out_sum, out_cout, out_ovf, out_zero};
      checks++;
      if (got !== e || !out_valid || in_ready) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d sum=%h v=%b r=%b required %h/1/0",
                 k, out_sum, out_valid, in_ready, e.sum);
      end
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL hold_pre_release out_valid=%b required 1", out_valid);
    end
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL hold_release got=%b required 10",
               {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid;
    exp_t e, got;
    bit   seen = 0;
    bit   ok = 0;
    e = '{sum: 32'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    accept_op(32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1, 0, e);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero,
         rca_a, rca_b, rca_cin} !== {1'b1, {(W+21){1'b0}}}) begin
      failures++;
      $display("FAIL rstmid_outs r=%b v=%b sum=%h c%b o%b z%b rca=%h/%h/%b",
               in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero,
               rca_a, rca_b, rca_cin);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3 * NB; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rstmid_ghost out_valid=1 required 0");
    end
    e = '{sum: 32'h0, cout: 1'b1, ovf: 1'b1, zero: 1'b1};
    accept_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1, e);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    checks++;
    e   = sb.pop_front();
    got = {out_sum, out_cout, out_ovf, out_zero};
    if (!ok || got !== e) begin
      failures++;
      $display("FAIL rstmid_next v=%b got=%h/%b%b%b required %h/%b%b%b",
               out_valid, got.sum, got.cout, got.ovf, got.zero,
               e.sum, e.cout, e.ovf, e.zero);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

`ifdef BSA_SUBTRACT_EN
  task automatic test_subtract;
    exp_t e, got;
    bit   ok = 0;
    e = '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    op_sub = 1'b1;
    accept_op(32'd5, 32'd7, 1'b0, 1, e);
    op_sub = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    checks++;
    e   = sb.pop_front();
    got = {out_sum, out_cout, out_ovf, out_zero};
    if (!ok || got !== e) begin
      failures++;
      $display("FAIL sub_result v=%b got=%h/%b%b%b required %h/%b%b%b",
               out_valid, got.sum, got.cout, got.ovf, got.zero,
               e.sum, e.cout, e.ovf, e.zero);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask
`endif

  task automatic test_back_to_back;
    int acc[4];
    out_ready = 1'b1;
    fork
      begin
        logic [W-1:0] a, b;
        logic         c;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
          bit ok = 0;
          a = $urandom; b = $urandom; c = 1'($urandom);
          if (i == 1) begin a = 32'h7FFF_0000; b = 32'h7FFF_0000; end
          in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
          for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
          end
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL b2b_accept_timeout op=%0d", i);
          end
          acc[i] = cyc;
          sb.push_back(model(a, b, c));
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        exp_t e, got;
        int   n = 0;
        for (int j = 0; j < 200 && n < 4; j++) begin
          @(negedge clk);
          if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL b2b_sb_empty op=%0d", n);
            end else begin
              e   = sb.pop_front();
              got = {out_sum, out_cout, out_ovf, out_zero};
              if (got !== e) begin
                failures++;
                $display("FAIL b2b_result op=%0d got=%h/%b%b%b required %h/%b%b%b",
                         n, got.sum, got.cout, got.ovf, got.zero,
                         e.sum, e.cout, e.ovf, e.zero);
              end
            end
            n++;
          end
        end
        checks++;
        if (n != 4) begin
          failures++;
          $display("FAIL b2b_count got=%0d required 4", n);
        end
      end
    join
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc[i] - acc[i-1] != NB + 2) begin
        failures++;
        $display("FAIL b2b_spacing op=%0d got=%0d required %0d",
                 i, acc[i] - acc[i-1], NB + 2);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
`ifdef BSA_SUBTRACT_EN
    op_sub    = 1'b0;
`endif
    test_reset;
    test_carry_wrap;
    test_ovf;
    test_hold;
    test_reset_mid;
`ifdef BSA_SUBTRACT_EN
    test_subtract;
`endif
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
